user_wb_target_ctrl: RTL and testbench

//  Wishbone transaction controller between the management SoC slave port (wbs_*) of the user area and up to NUM_TGT

---
 rtl/user_wb_target_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_user_wb_target_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/user_wb_target_ctrl.sv
// Wishbone transaction controller: decodes mgmt accesses into one of NUM_TGT
// user target windows and runs one target transaction at a time. Every access
// is acked; address misses and target timeouts return ERR_DATA.
//
// state  | meaning
// IDLE   | waiting for a mgmt request; decodes address on cyc&stb
// ACTIVE | target strobe asserted, waiting for the selected ack or timeout
// RESP   | one-cycle ack back to mgmt with captured data or ERR_DATA
module user_wb_target_ctrl #(
    parameter int          NUM_TGT   = 4,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          SPAN_LOG2 = 16,
    parameter int          TIMEOUT   = 255,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    wbs_cyc_i,
    input  logic                    wbs_stb_i,
    input  logic                    wbs_we_i,
    input  logic [3:0]              wbs_sel_i,
    input  logic [31:0]             wbs_adr_i,
    input  logic [31:0]             wbs_dat_i,
    output logic                    wbs_ack_o,
    output logic [31:0]             wbs_dat_o,
    output logic                    tgt_cyc_o,
    output logic [NUM_TGT-1:0]      tgt_stb_o,
    output logic                    tgt_we_o,
    output logic [3:0]              tgt_sel_o,
    output logic [SPAN_LOG2-1:0]    tgt_adr_o,
    output logic [31:0]             tgt_dat_o,
    input  logic [NUM_TGT-1:0]      tgt_ack_i,
    input  logic [NUM_TGT*32-1:0]   tgt_dat_i,
    output logic                    err_irq_o,
    output logic [15:0]             err_cnt_o,
    output logic [31:0]             last_err_adr_o
);

    localparam int IDXW    = $clog2(NUM_TGT);
    localparam int TW      = $clog2(TIMEOUT + 1);
    localparam int TAG_LSB = SPAN_LOG2 + IDXW;
    localparam logic [NUM_TGT-1:0] STB_ONE = NUM_TGT'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic            we_q;
    logic [3:0]      sel_q;
    logic [31:0]     adr_q;
    logic [31:0]     dat_q;
    logic [IDXW-1:0] idx_q;
    logic [TW-1:0]   timer;

    logic        req;
    logic        hit;
    logic        sel_ack;
    logic        timeout;
    logic        go_resp;
    logic        rsp_err;
    logic [31:0] rsp_data;
    logic [31:0] err_adr;
    logic [15:0] err_cnt;
    logic [15:0] err_cnt_nxt;

    assign req     = wbs_cyc_i & wbs_stb_i;
    assign hit     = (wbs_adr_i[31:TAG_LSB] == BASE_ADDR[31:TAG_LSB]);
    assign sel_ack = tgt_ack_i[idx_q];
    assign timeout = (timer == '0);

    // A miss is reported while still in IDLE, so its address comes straight off the bus.
    assign err_adr = (state == IDLE) ? wbs_adr_i : adr_q;

    // Next-state decode and response selection; go_resp marks the edge into RESP.
    always_comb begin
        state_nxt = state;
        go_resp   = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        state_nxt = ACTIVE;
                    end else begin
                        state_nxt = RESP;
                        go_resp   = 1'b1;
                        rsp_err   = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                // A vanished mgmt cycle takes priority: nobody is left to ack.
                if (!wbs_cyc_i) begin
                    state_nxt = IDLE;
                end else if (sel_ack) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                    if (!we_q) begin
                        rsp_data = tgt_dat_i[32*int'(idx_q) +: 32];
                    end
                end else if (timeout) begin
                    state_nxt = RESP;
                    go_resp   = 1'b1;
                    rsp_err   = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Saturating error counter next value.
    always_comb begin
        err_cnt_nxt = err_cnt;
        if (go_resp && rsp_err && (err_cnt != 16'hFFFF)) begin
            err_cnt_nxt = err_cnt + 16'd1;
        end
    end

    // State register.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the mgmt request when it is accepted in IDLE; held through ACTIVE.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            we_q  <= 1'b0;
            sel_q <= '0;
            adr_q <= '0;
            dat_q <= '0;
            idx_q <= '0;
        end else if ((state == IDLE) && req) begin
            we_q  <= wbs_we_i;
            sel_q <= wbs_sel_i;
            adr_q <= wbs_adr_i;
            dat_q <= wbs_dat_i;
            idx_q <= wbs_adr_i[SPAN_LOG2 +: IDXW];
        end
    end

    // Timeout down-counter: preloaded outside ACTIVE, expires at zero on the
    // (TIMEOUT+1)-th ACTIVE cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || (state != ACTIVE)) begin
            timer <= TW'(TIMEOUT);
        end else if (!timeout) begin
            timer <= timer - TW'(1);
        end
    end

    // Registered response, error pulse, error counter and error address.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbs_ack_o      <= 1'b0;
            wbs_dat_o      <= '0;
            err_irq_o      <= 1'b0;
            err_cnt        <= '0;
            last_err_adr_o <= '0;
        end else begin
            wbs_ack_o <= go_resp;
            err_irq_o <= go_resp & rsp_err;
            err_cnt   <= err_cnt_nxt;
            if (go_resp) begin
                wbs_dat_o <= rsp_err ? ERR_DATA : rsp_data;
            end
            if (go_resp && rsp_err) begin
                last_err_adr_o <= err_adr;
            end
        end
    end

    assign err_cnt_o = err_cnt;
    assign tgt_cyc_o = (state == ACTIVE);
    assign tgt_stb_o = tgt_cyc_o ? (STB_ONE << idx_q) : '0;
    assign tgt_we_o  = we_q;
    assign tgt_sel_o = sel_q;
    assign tgt_adr_o = adr_q[SPAN_LOG2-1:0];
    assign tgt_dat_o = dat_q;

endmodule

// File: tb/tb_user_wb_target_ctrl.sv
// Self-checking bench for user_wb_target_ctrl: directed transactions with a
// per-cycle transaction model and literal checks on latency and data.
module tb_user_wb_target_ctrl;

    localparam logic [31:0] BASE    = 32'h3000_0000;
    localparam logic [31:0] ERR     = 32'hDEAD_BEEF;
    localparam int          TIMEOUT = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic          wbs_cyc, wbs_stb, wbs_we;
    logic [3:0]    wbs_sel;
    logic [31:0]   wbs_adr, wbs_dat;
    logic          wbs_ack_o;
    logic [31:0]   wbs_dat_o;
    logic          tgt_cyc_o;
    logic [3:0]    tgt_stb_o;
    logic          tgt_we_o;
    logic [3:0]    tgt_sel_o;
    logic [15:0]   tgt_adr_o;
    logic [31:0]   tgt_dat_o;
    logic [3:0]    tgt_ack;
    logic [127:0]  tgt_dat;
    logic          err_irq_o;
    logic [15:0]   err_cnt_o;
    logic [31:0]   last_err_adr_o;

    user_wb_target_ctrl dut (
        .wb_clk_i       (clk),
        .wb_rst_i       (rst),
        .wbs_cyc_i      (wbs_cyc),
        .wbs_stb_i      (wbs_stb),
        .wbs_we_i       (wbs_we),
        .wbs_sel_i      (wbs_sel),
        .wbs_adr_i      (wbs_adr),
        .wbs_dat_i      (wbs_dat),
        .wbs_ack_o      (wbs_ack_o),
        .wbs_dat_o      (wbs_dat_o),
        .tgt_cyc_o      (tgt_cyc_o),
        .tgt_stb_o      (tgt_stb_o),
        .tgt_we_o       (tgt_we_o),
        .tgt_sel_o      (tgt_sel_o),
        .tgt_adr_o      (tgt_adr_o),
        .tgt_dat_o      (tgt_dat_o),
        .tgt_ack_i      (tgt_ack),
        .tgt_dat_i      (tgt_dat),
        .err_irq_o      (err_irq_o),
        .err_cnt_o      (err_cnt_o),
        .last_err_adr_o (last_err_adr_o)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc_cnt = 0;
    int t0 = 0;
    int ack_cyc = -1;
    int irq_seen = 0;
    logic [3:0] stb_seen = '0;
    bit chk_en = 1'b0;

    logic        exp_ack, exp_irq, exp_cyc, exp_we;
    logic [3:0]  exp_stb, exp_sel;
    logic [15:0] exp_adr, exp_cnt;
    logic [31:0] exp_wdat, exp_dat, exp_last;

    always @(posedge clk) cyc_cnt++;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // Per-cycle compare against the transaction model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wbs_ack", {31'd0, wbs_ack_o}, {31'd0, exp_ack});
            chk("err_irq", {31'd0, err_irq_o}, {31'd0, exp_irq});
            chk("tgt_cyc", {31'd0, tgt_cyc_o}, {31'd0, exp_cyc});
            chk("tgt_stb", {28'd0, tgt_stb_o}, {28'd0, exp_stb});
            chk("wbs_dat", wbs_dat_o, exp_dat);
            chk("err_cnt", {16'd0, err_cnt_o}, {16'd0, exp_cnt});
            chk("last_err_adr", last_err_adr_o, exp_last);
            if (exp_cyc) begin
                chk("tgt_we", {31'd0, tgt_we_o}, {31'd0, exp_we});
                chk("tgt_sel", {28'd0, tgt_sel_o}, {28'd0, exp_sel});
                chk("tgt_adr", {16'd0, tgt_adr_o}, {16'd0, exp_adr});
                chk("tgt_dat", tgt_dat_o, exp_wdat);
            end
            if (wbs_ack_o === 1'b1) ack_cyc = cyc_cnt - t0;
            if (err_irq_o === 1'b1) irq_seen++;
            stb_seen |= tgt_stb_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
        wbs_sel = '0; wbs_adr = '0; wbs_dat = '0;
        tgt_ack = '0;
        exp_ack = 1'b0; exp_irq = 1'b0; exp_cyc = 1'b0; exp_stb = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_idle();
            step();
        end
    endtask

    task automatic note_err(input logic [31:0] adr);
        exp_irq  = 1'b1;
        exp_last = adr;
        if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    endtask

    // One mgmt access. ack_after: ACTIVE cycles before the target acks (-1 never).
    // abort_at / rst_at: ACTIVE cycle in which cyc is dropped / reset asserted (0 = no).
    task automatic txn(input logic [31:0] adr, input logic we, input logic [31:0] wdat,
                       input logic [3:0] sel, input logic [31:0] rdat, input int ack_after,
                       input bit stray, input int abort_at, input int rst_at);
        logic hit;
        int   idx;
        bit   acked;
        int   k;
        hit   = (adr[31:18] == BASE[31:18]);
        idx   = int'(adr[17:16]);
        acked = 1'b0;
        t0 = cyc_cnt;
        ack_cyc = -1;
        irq_seen = 0;
        stb_seen = '0;
        wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = we;
        wbs_sel = sel; wbs_adr = adr; wbs_dat = wdat;
        tgt_ack = '0;
        for (int j = 0; j < 4; j++)
            tgt_dat[32*j +: 32] = (j == idx) ? rdat : (32'h0BAD_0000 + 32'(j));
        exp_ack = 1'b0; exp_irq = 1'b0; exp_cyc = 1'b0; exp_stb = '0;
        exp_we = we; exp_sel = sel; exp_adr = adr[15:0]; exp_wdat = wdat;
        step();
        if (!hit) begin
            exp_ack = 1'b1;
            exp_dat = ERR;
            note_err(adr);
            step();
            set_idle();
            return;
        end
        k = 1;
        while (1) begin
            exp_cyc = 1'b1;
            exp_stb = 4'b0001 << idx;
            exp_ack = 1'b0;
            exp_irq = 1'b0;
            tgt_ack = '0;
            if (ack_after == k - 1) begin
                tgt_ack[idx] = 1'b1;
                acked = 1'b1;
            end else if (stray && k == 3) begin
                tgt_ack[0] = 1'b1;
            end
            if (abort_at == k) begin
                wbs_cyc = 1'b0;
                wbs_stb = 1'b0;
            end
            if (rst_at == k) rst = 1'b1;
            step();
            if (abort_at == k) begin
                set_idle();
                return;
            end
            if (rst_at == k) begin
                rst = 1'b0;
                exp_dat = '0; exp_cnt = '0; exp_last = '0;
                set_idle();
                return;
            end
            if (acked || k == TIMEOUT + 1) break;
            k++;
        end
        tgt_ack = '0;
        exp_cyc = 1'b0;
        exp_stb = '0;
        exp_ack = 1'b1;
        if (acked) begin
            exp_dat = we ? 32'd0 : rdat;
        end else begin
            exp_dat = ERR;
            note_err(adr);
        end
        step();
        set_idle();
    endtask

    initial begin
        rst = 1'b1;
        tgt_dat = '0;
        set_idle();
        exp_dat = '0; exp_cnt = '0; exp_last = '0;
        exp_we = 1'b0; exp_sel = '0; exp_adr = '0; exp_wdat = '0;
        step();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle(2);

        // Read hit, target 1 acks in its first strobe cycle.
        txn(32'h3001_0010, 1'b0, 32'h0, 4'hF, 32'h1234_5678, 0, 1'b0, 0, 0);
        chk("t1_ack_cycle", ack_cyc, 2);
        chk("t1_rdata", wbs_dat_o, 32'h1234_5678);
        chk("t1_stb_seen", {28'd0, stb_seen}, 32'h2);
        chk("t1_err_cnt", {16'd0, err_cnt_o}, 32'd0);
        idle(1);

        // Write hit, target 3 acks after 5 wait cycles.
        txn(32'h3003_0004, 1'b1, 32'hA5A5_A5A5, 4'b0011, 32'hFFFF_0000, 5, 1'b0, 0, 0);
        chk("t2_ack_cycle", ack_cyc, 7);
        chk("t2_wdata_rsp", wbs_dat_o, 32'h0);
        chk("t2_stb_seen", {28'd0, stb_seen}, 32'h8);
        idle(1);

        // Address miss.
        txn(32'h2000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 0, 0);
        chk("t3_ack_cycle", ack_cyc, 1);
        chk("t3_rdata", wbs_dat_o, 32'hDEAD_BEEF);
        chk("t3_err_cnt", {16'd0, err_cnt_o}, 32'd1);
        chk("t3_last_err", last_err_adr_o, 32'h2000_0000);
        chk("t3_irq_pulses", irq_seen, 1);
        chk("t3_no_stb", {28'd0, stb_seen}, 32'h0);
        idle(1);

        // Target 2 never acks; stray ack on target 0 must be ignored.
        txn(32'h3002_0000, 1'b0, 32'h0, 4'hF, 32'h7777_7777, -1, 1'b1, 0, 0);
        chk("t4_ack_cycle", ack_cyc, 257);
        chk("t4_rdata", wbs_dat_o, 32'hDEAD_BEEF);
        chk("t4_err_cnt", {16'd0, err_cnt_o}, 32'd2);
        chk("t4_last_err", last_err_adr_o, 32'h3002_0000);
        idle(1);

        // Ack arrives on the timeout cycle itself: the ack wins.
        txn(32'h3000_0020, 1'b0, 32'h0, 4'hF, 32'h5555_AAAA, TIMEOUT, 1'b0, 0, 0);
        chk("t4b_ack_cycle", ack_cyc, 257);
        chk("t4b_rdata", wbs_dat_o, 32'h5555_AAAA);
        chk("t4b_err_cnt", {16'd0, err_cnt_o}, 32'd2);
        idle(1);

        // Mgmt drops cyc mid-ACTIVE.
        txn(32'h3001_0000, 1'b0, 32'h0, 4'hF, 32'h1111_1111, -1, 1'b0, 3, 0);
        idle(3);
        chk("t5_abort_no_ack", ack_cyc, -1);
        chk("t5_abort_err_cnt", {16'd0, err_cnt_o}, 32'd2);

        // Reset mid-ACTIVE.
        txn(32'h3002_0040, 1'b0, 32'h0, 4'hF, 32'h2222_2222, -1, 1'b0, 0, 3);
        idle(3);
        chk("t5_rst_no_ack", ack_cyc, -1);
        chk("t5_rst_err_cnt", {16'd0, err_cnt_o}, 32'd0);

        // Counter saturation.
        set_idle();
        exp_cnt = 16'hFFFE;
        force dut.err_cnt = 16'hFFFE;
        step();
        release dut.err_cnt;
        idle(1);
        txn(32'h4000_0000, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 0, 0);
        chk("t6_cnt_first", {16'd0, err_cnt_o}, 32'h0000_FFFF);
        txn(32'h3004_0000, 1'b1, 32'h1234_0000, 4'hF, 32'h0, 0, 1'b0, 0, 0);
        txn(32'h2FFF_FFFC, 1'b0, 32'h0, 4'hF, 32'h0, 0, 1'b0, 0, 0);
        chk("t6_cnt_sat", {16'd0, err_cnt_o}, 32'h0000_FFFF);
        chk("t6_last_err", last_err_adr_o, 32'h2FFF_FFFC);
        idle(1);

        // Back-to-back reads to target 0 then target 1.
        txn(32'h3000_0100, 1'b0, 32'h0, 4'hF, 32'h0000_0A0A, 0, 1'b0, 0, 0);
        chk("t7_first_rdata", wbs_dat_o, 32'h0000_0A0A);
        txn(32'h3001_0200, 1'b0, 32'h0, 4'hF, 32'h0000_0B0B, 0, 1'b0, 0, 0);
        chk("t7_second_rdata", wbs_dat_o, 32'h0000_0B0B);
        chk("t7_second_ack_cycle", ack_cyc, 2);
        idle(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
